// File: rtl/paddle_array_ctrl_if.sv
// Paddle array controller bus: button/mode inputs and position/status outputs.
// The master side drives buttons and game controls; the slave side is the controller.
interface paddle_array_ctrl_if #(
   parameter int N_PADDLE = 2,
   parameter int POS_W    = 10
);
   logic [N_PADDLE-1:0]       btn_up_n;
   logic [N_PADDLE-1:0]       btn_dn_n;
   logic [1:0]                game_state;
   logic [N_PADDLE-1:0]       move_en;
   logic                      recenter;
   logic [N_PADDLE*POS_W-1:0] pos;
   logic [N_PADDLE-1:0]       at_min;
   logic [N_PADDLE-1:0]       at_max;
   logic [N_PADDLE-1:0]       moving;

   modport master (
      output btn_up_n, btn_dn_n, game_state, move_en, recenter,
      input  pos, at_min, at_max, moving
   );

   modport slave (
      input  btn_up_n, btn_dn_n, game_state, move_en, recenter,
      output pos, at_min, at_max, moving
   );
endinterface

// File: rtl/paddle_array_ctrl.sv
// Paddle array controller: synchronises and debounces per-paddle up/down
// buttons, then moves each paddle with an accelerating step while a direction
// is held, saturating at the clamp bounds. Game-over and recenter force home.
module paddle_array_ctrl #(
   parameter int N_PADDLE   = 2,
   parameter int POS_W      = 10,
   parameter int POS_MIN    = 140,
   parameter int POS_MAX    = 340,
   parameter int POS_CENTER = 220,
   parameter int STEP_BASE  = 10,
   parameter int STEP_MAX   = 40,
   parameter int DEB_CYC    = 4,
   parameter int REPEAT_CYC = 8
) (
   input  logic               clk,
   input  logic               reset,
   paddle_array_ctrl_if.slave bus
);
   localparam int N_BTN = 2 * N_PADDLE;
   localparam int DEB_W = $clog2(DEB_CYC + 1);
   localparam int RPT_W = $clog2(REPEAT_CYC + 1);

   localparam logic [DEB_W-1:0]        DEB_LAST = DEB_W'(DEB_CYC - 1);
   localparam logic [RPT_W-1:0]        RPT_LAST = RPT_W'(REPEAT_CYC - 1);
   localparam logic [POS_W-1:0]        CENTER   = POS_W'(POS_CENTER);
   localparam logic [POS_W-1:0]        MIN_U    = POS_W'(POS_MIN);
   localparam logic [POS_W-1:0]        MAX_U    = POS_W'(POS_MAX);
   localparam logic signed [POS_W:0]   MIN_S    = (POS_W+1)'(POS_MIN);
   localparam logic signed [POS_W:0]   MAX_S    = (POS_W+1)'(POS_MAX);
   localparam logic [POS_W-1:0]        STEP_B   = POS_W'(STEP_BASE);
   localparam logic [POS_W-1:0]        STEP_MX  = POS_W'(STEP_MAX);
   localparam logic [POS_W:0]          STEP_MW  = (POS_W+1)'(STEP_MAX);

   typedef enum logic [1:0] {
      MV_HOLD = 2'd0,
      MV_UP   = 2'd1,
      MV_DN   = 2'd2
   } mv_dir_t;

   // Buttons flattened: [N_PADDLE-1:0] are up, [2*N_PADDLE-1:N_PADDLE] are down.
   logic [N_BTN-1:0] btn_raw_n;
   logic [N_BTN-1:0] btn_deb_n;
   logic             play;

   assign btn_raw_n = {bus.btn_dn_n, bus.btn_up_n};
   assign play      = (bus.game_state == 2'd0) || (bus.game_state == 2'd1);

   generate
      for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
         logic [1:0]       sync_reg;
         logic             deb_reg;
         logic [DEB_W-1:0] cnt_reg;

         // Two-flop synchroniser, then flip the debounced level only after
         // DEB_CYC consecutive disagreeing samples.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               sync_reg <= 2'b11;
               deb_reg  <= 1'b1;
               cnt_reg  <= '0;
            end else begin
               sync_reg <= {sync_reg[0], btn_raw_n[gi]};
               if (sync_reg[1] == deb_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == DEB_LAST) begin
                  deb_reg <= sync_reg[1];
                  cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end

         assign btn_deb_n[gi] = deb_reg;
      end

      for (genvar gi = 0; gi < N_PADDLE; gi++) begin : g_pad
         mv_dir_t               st_reg, st_next, dir;
         logic [POS_W-1:0]      pos_reg, pos_next, pos_move;
         logic [POS_W-1:0]      step_reg, step_next, mv_step;
         logic [RPT_W-1:0]      rpt_reg, rpt_next;
         logic [POS_W:0]        step_dbl;
         logic signed [POS_W:0] pos_sum;
         logic                  do_move;
         logic                  moving_reg;

         // Direction state, current step, repeat timer and position registers.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               st_reg     <= MV_HOLD;
               step_reg   <= STEP_B;
               rpt_reg    <= '0;
               pos_reg    <= CENTER;
               moving_reg <= 1'b0;
            end else begin
               st_reg     <= st_next;
               step_reg   <= step_next;
               rpt_reg    <= rpt_next;
               pos_reg    <= pos_next;
               moving_reg <= (pos_next != pos_reg);
            end
         end

         // Decide whether a move happens this clock, its step, and the
         // saturated next position; game-over and recenter override moves.
         always_comb begin
            dir       = MV_HOLD;
            st_next   = st_reg;
            step_next = step_reg;
            rpt_next  = rpt_reg;
            mv_step   = step_reg;
            do_move   = 1'b0;
            step_dbl  = {step_reg, 1'b0};
            pos_sum   = '0;
            pos_move  = pos_reg;
            pos_next  = pos_reg;

            if (!btn_deb_n[gi] && btn_deb_n[N_PADDLE+gi]) begin
               dir = MV_UP;
            end else if (btn_deb_n[gi] && !btn_deb_n[N_PADDLE+gi]) begin
               dir = MV_DN;
            end

            if (!play || !bus.move_en[gi] || dir == MV_HOLD) begin
               st_next   = MV_HOLD;
               step_next = STEP_B;
               rpt_next  = '0;
            end else if (st_reg != dir) begin
               // Fresh press or reversal: move immediately with the base step.
               st_next   = dir;
               step_next = STEP_B;
               rpt_next  = '0;
               mv_step   = STEP_B;
               do_move   = 1'b1;
            end else if (rpt_reg == RPT_LAST) begin
               mv_step   = (step_dbl > STEP_MW) ? STEP_MX : step_dbl[POS_W-1:0];
               step_next = mv_step;
               rpt_next  = '0;
               do_move   = 1'b1;
            end else begin
               rpt_next = rpt_reg + 1'b1;
            end

            if (dir == MV_UP) begin
               pos_sum = $signed({1'b0, pos_reg}) - $signed({1'b0, mv_step});
            end else begin
               pos_sum = $signed({1'b0, pos_reg}) + $signed({1'b0, mv_step});
            end

            if (pos_sum < MIN_S) begin
               pos_move = MIN_U;
            end else if (pos_sum > MAX_S) begin
               pos_move = MAX_U;
            end else begin
               pos_move = pos_sum[POS_W-1:0];
            end

            if (!play || bus.recenter) begin
               pos_next = CENTER;
            end else if (do_move) begin
               pos_next = pos_move;
            end
         end

         assign bus.pos[gi*POS_W +: POS_W] = pos_reg;
         assign bus.at_min[gi]             = (pos_reg == MIN_U);
         assign bus.at_max[gi]             = (pos_reg == MAX_U);
         assign bus.moving[gi]             = moving_reg;
      end
   endgenerate
endmodule

// File: tb/tb_paddle_array_ctrl.sv
// Testbench for paddle_array_ctrl: directed scenarios plus a randomized phase,
// all outputs compared every clock against a behavioural model.
module tb_paddle_array_ctrl;
   localparam int NP    = 2;
   localparam int PW    = 10;
   localparam int PMIN  = 140;
   localparam int PMAX  = 340;
   localparam int PCEN  = 220;
   localparam int SBASE = 10;
   localparam int SMAX  = 40;
   localparam int DEB   = 4;
   localparam int RPT   = 8;
   localparam int NB    = 2 * NP;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   paddle_array_ctrl_if #(.N_PADDLE(NP), .POS_W(PW)) bus ();

   paddle_array_ctrl #(
      .N_PADDLE(NP), .POS_W(PW), .POS_MIN(PMIN), .POS_MAX(PMAX),
      .POS_CENTER(PCEN), .STEP_BASE(SBASE), .STEP_MAX(SMAX),
      .DEB_CYC(DEB), .REPEAT_CYC(RPT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: positions, hold age (edges since the first move of the current
   // hold, 0 = idle) and last direction per paddle; per button the raw
   // samples of the previous two edges, a window of synchronised samples and
   // the debounced level.
   int m_pos[NP];
   int m_mov[NP];
   int m_held[NP];
   int m_lastdir[NP];
   int m_deb[NB];
   int m_q1[NB];
   int m_q2[NB];
   int m_win[NB][DEB];
   int mv_cnt[NP];

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int raw_btn(int b);
      if (b < NP) return int'(bus.btn_up_n[b]);
      return int'(bus.btn_dn_n[b-NP]);
   endfunction

   function automatic logic [31:0] dpos(int i);
      return 32'(bus.pos[i*PW +: PW]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NP; i++) begin
         m_pos[i] = PCEN; m_mov[i] = 0; m_held[i] = 0; m_lastdir[i] = 0;
      end
      for (int b = 0; b < NB; b++) begin
         m_deb[b] = 1; m_q1[b] = 1; m_q2[b] = 1;
         for (int k = 0; k < DEB; k++) m_win[b][k] = 1;
      end
   endtask

   task automatic model_step();
      int  dir, stp, k, nxt, old, up, dn, seen;
      bit  play, mv, all_diff;
      if (reset) begin
         model_reset();
         return;
      end
      play = (bus.game_state < 2);
      for (int i = 0; i < NP; i++) begin
         up  = (m_deb[i] == 0) ? 1 : 0;
         dn  = (m_deb[NP+i] == 0) ? 1 : 0;
         dir = (up == 1 && dn == 0) ? -1 : (dn == 1 && up == 0) ? 1 : 0;
         old = m_pos[i];
         mv  = 0;
         stp = 0;
         if (!play) begin
            m_pos[i] = PCEN; m_held[i] = 0; m_lastdir[i] = 0;
         end else begin
            if (bus.move_en[i] == 1'b0 || dir == 0) begin
               m_held[i] = 0; m_lastdir[i] = 0;
            end else begin
               if (dir != m_lastdir[i]) m_held[i] = 0;
               if (m_held[i] % RPT == 0) begin
                  k   = m_held[i] / RPT;
                  stp = SBASE;
                  for (int j = 0; j < k && stp < SMAX; j++) stp = stp * 2;
                  if (stp > SMAX) stp = SMAX;
                  mv = 1;
               end
               m_held[i]++;
               m_lastdir[i] = dir;
            end
            if (bus.recenter) begin
               m_pos[i] = PCEN;
            end else if (mv) begin
               nxt = m_pos[i] + dir * stp;
               if (nxt < PMIN) nxt = PMIN;
               if (nxt > PMAX) nxt = PMAX;
               m_pos[i] = nxt;
            end
         end
         m_mov[i] = (m_pos[i] != old) ? 1 : 0;
      end
      for (int b = 0; b < NB; b++) begin
         seen    = m_q2[b];
         m_q2[b] = m_q1[b];
         m_q1[b] = raw_btn(b);
         for (int q = DEB - 1; q > 0; q--) m_win[b][q] = m_win[b][q-1];
         m_win[b][0] = seen;
         all_diff = 1;
         for (int q = 0; q < DEB; q++) if (m_win[b][q] == m_deb[b]) all_diff = 0;
         if (all_diff) m_deb[b] = seen;
      end
   endtask

   task automatic check_all(string tag);
      for (int i = 0; i < NP; i++) begin
         chk($sformatf("%s pos[%0d]", tag, i), dpos(i), m_pos[i]);
         chk($sformatf("%s moving[%0d]", tag, i), 32'(bus.moving[i]), m_mov[i]);
         chk($sformatf("%s at_min[%0d]", tag, i), 32'(bus.at_min[i]), (m_pos[i] == PMIN) ? 1 : 0);
         chk($sformatf("%s at_max[%0d]", tag, i), 32'(bus.at_max[i]), (m_pos[i] == PMAX) ? 1 : 0);
      end
   endtask

   task automatic tick(string tag);
      @(posedge clk);
      model_step();
      #1;
      for (int i = 0; i < NP; i++) mv_cnt[i] += int'(bus.moving[i]);
      check_all(tag);
   endtask

   task automatic run(int n, string tag);
      repeat (n) tick(tag);
   endtask

   task automatic clr_mv();
      for (int i = 0; i < NP; i++) mv_cnt[i] = 0;
   endtask

   task automatic recenter_pulse();
      bus.recenter = 1'b1;
      tick("recenter");
      bus.recenter = 1'b0;
   endtask

   task automatic async_reset_pulse(string tag);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check_all(tag);
      tick(tag);
      reset = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      bus.btn_up_n   = '1;
      bus.btn_dn_n   = '1;
      bus.game_state = 2'd1;
      bus.move_en    = '1;
      bus.recenter   = 1'b0;
      model_reset();
      clr_mv();
      #1;
      check_all("reset");
      chk("reset pos0", dpos(0), PCEN);
      run(2, "reset");
      reset = 1'b0;
      run(3, "idle");

      // Held up on paddle 0: accelerating moves down to the lower clamp.
      bus.btn_up_n[0] = 1'b0;
      clr_mv();
      run(7, "hold_up");
      chk("hold_up T0+6", dpos(0), 210);
      run(8, "hold_up");
      chk("hold_up T0+14", dpos(0), 190);
      run(8, "hold_up");
      chk("hold_up T0+22", dpos(0), 150);
      run(8, "hold_up");
      chk("hold_up T0+30", dpos(0), 140);
      chk("hold_up at_min0", 32'(bus.at_min[0]), 1);
      run(9, "hold_up_sat");
      chk("hold_up pulses", mv_cnt[0], 4);
      bus.btn_up_n[0] = 1'b1;
      run(8, "release");
      recenter_pulse();
      chk("recenter pos0", dpos(0), PCEN);
      run(2, "idle");

      // Two-clock glitch on paddle 1 down must be filtered out.
      bus.btn_dn_n[1] = 1'b0;
      clr_mv();
      run(2, "glitch");
      bus.btn_dn_n[1] = 1'b1;
      run(12, "glitch");
      chk("glitch moving1", mv_cnt[1], 0);
      chk("glitch pos1", dpos(1), PCEN);

      // Both buttons on paddle 0 hold it; paddle 1 runs to the upper clamp.
      bus.btn_up_n[0] = 1'b0;
      bus.btn_dn_n[0] = 1'b0;
      bus.btn_dn_n[1] = 1'b0;
      clr_mv();
      run(7, "both");
      chk("both pos1 230", dpos(1), 230);
      run(8, "both");
      chk("both pos1 250", dpos(1), 250);
      run(8, "both");
      chk("both pos1 290", dpos(1), 290);
      run(8, "both");
      chk("both pos1 330", dpos(1), 330);
      run(8, "both");
      chk("both pos1 340", dpos(1), 340);
      chk("both at_max1", 32'(bus.at_max[1]), 1);
      chk("both pos0", dpos(0), PCEN);
      chk("both moving0", mv_cnt[0], 0);
      bus.btn_up_n = '1;
      bus.btn_dn_n = '1;
      run(8, "release");
      recenter_pulse();

      // Recenter coincident with a scheduled repeat move of paddle 1 at 250.
      bus.btn_dn_n[1] = 1'b0;
      run(7, "rc_move");
      chk("rc_move pos1 230", dpos(1), 230);
      run(8, "rc_move");
      chk("rc_move pos1 250", dpos(1), 250);
      run(7, "rc_move");
      bus.recenter = 1'b1;
      tick("rc_move");
      bus.recenter = 1'b0;
      chk("rc_move pos1 centered", dpos(1), PCEN);
      bus.btn_dn_n[1] = 1'b1;
      run(8, "release");

      // Game over forces home and freezes movement until play resumes.
      bus.btn_dn_n[0] = 1'b0;
      run(23, "gs");
      chk("gs pos0 290", dpos(0), 290);
      bus.btn_dn_n[0] = 1'b1;
      run(8, "gs");
      bus.btn_dn_n[0] = 1'b0;
      run(7, "gs");
      chk("gs pos0 300", dpos(0), 300);
      bus.game_state = 2'd2;
      tick("gs_done");
      chk("gs_done pos0", dpos(0), PCEN);
      run(20, "gs_done");
      chk("gs_done hold pos0", dpos(0), PCEN);
      bus.game_state = 2'd1;
      tick("gs_play");
      chk("gs_play pos0", dpos(0), 230);
      bus.btn_dn_n[0] = 1'b1;
      run(8, "release");
      recenter_pulse();

      // Reset mid-hold: immediate home, then full requalification.
      bus.btn_up_n[0] = 1'b0;
      run(7, "rst_hold");
      chk("rst_hold pos0 210", dpos(0), 210);
      run(8, "rst_hold");
      chk("rst_hold pos0 190", dpos(0), 190);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk("async reset pos0", dpos(0), PCEN);
      check_all("async reset");
      run(2, "in_reset");
      reset = 1'b0;
      run(6, "requal");
      chk("requal pos0 still", dpos(0), PCEN);
      tick("requal");
      chk("requal pos0 210", dpos(0), 210);
      bus.btn_up_n[0] = 1'b1;
      run(8, "release");

      // Randomized phase against the model.
      for (int n = 0; n < 1500; n++) begin
         for (int b = 0; b < NP; b++) begin
            if ($urandom_range(0, 19) == 0) bus.btn_up_n[b] = ~bus.btn_up_n[b];
            if ($urandom_range(0, 19) == 0) bus.btn_dn_n[b] = ~bus.btn_dn_n[b];
            if ($urandom_range(0, 39) == 0) bus.move_en[b] = ~bus.move_en[b];
         end
         if ($urandom_range(0, 59) == 0) begin
            bus.game_state = 2'($urandom_range(0, 3));
         end else if (bus.game_state[1] && $urandom_range(0, 7) == 0) begin
            bus.game_state = 2'd1;
         end
         bus.recenter = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 399) == 0) async_reset_pulse("rand_rst");
         tick("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/paddle_array_ctrl.md
PADDLE_ARRAY_CTRL -- requirements
Module: paddle_array_ctrl

Interface
REQ-001 SHALL have parameter N_PADDLE, default 2: number of independent paddles.
REQ-002 SHALL have parameter POS_W, default 10: position width in bits.
REQ-003 SHALL have parameters POS_MIN / POS_MAX / POS_CENTER, defaults 140 / 340 / 220: clamp bounds and home position.
REQ-004 SHALL have parameters STEP_BASE / STEP_MAX, defaults 10 / 40: first-move step and step ceiling.
REQ-005 SHALL have parameters DEB_CYC / REPEAT_CYC, defaults 4 / 8: debounce length and held-button repeat interval, in clocks.
REQ-006 SHALL use one clock; reset is asynchronous and active-high.
REQ-007 clk  in  1  system clock; all state updates on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 btn_up_n  in  N_PADDLE  per-paddle up button, active-low, asynchronous to clk.
REQ-010 btn_dn_n  in  N_PADDLE  per-paddle down button, active-low, asynchronous to clk.
REQ-011 game_state  in  2  0=serve, 1=playing, 2=done, 3=reserved (treated as done).
REQ-012 move_en  in  N_PADDLE  per-paddle movement enable; sampled every clock.
REQ-013 recenter  in  1  single-cycle request to return all paddles to POS_CENTER.
REQ-014 pos  out  N_PADDLE*POS_W  packed positions; paddle i occupies bits [i*POS_W +: POS_W].
REQ-015 at_min / at_max  out  N_PADDLE each  high while paddle i pos equals POS_MIN / POS_MAX.
REQ-016 moving  out  N_PADDLE  one-clock pulse on each clock in which paddle i pos changes.

Function
REQ-017 Each button SHALL pass through a 2-flop synchroniser before any other logic.
REQ-018 Debounced state SHALL change only after the synchronised level differs from it for DEB_CYC consecutive clocks; any agreeing sample clears the counter.
REQ-019 Direction per paddle: up-only = -1, down-only = +1; both or neither = hold with step reset.
REQ-020 A move SHALL occur on the clock after debounced direction becomes non-hold, i.e. DEB_CYC+2 clocks after the first edge sampling the press.
REQ-021 While the same direction is held, further moves SHALL occur every REPEAT_CYC clocks.
REQ-022 Step: first move STEP_BASE; each repeat step = min(2*previous, STEP_MAX); direction change or release resets to STEP_BASE.
REQ-023 Next position SHALL be computed in POS_W+1 signed bits and saturated to [POS_MIN, POS_MAX]; no wrap-around.
REQ-024 A move that saturates at the current bound (no change) SHALL NOT pulse moving.
REQ-025 Moves SHALL be applied only when game_state is 0 or 1 and move_en[i]=1; otherwise pos holds, and repeat timer and step are reset.
REQ-026 game_state 2 or 3 SHALL force all pos to POS_CENTER each clock, steps reset.
REQ-027 recenter=1 SHALL load POS_CENTER into all paddles next clock; recenter wins over a simultaneous move.
REQ-028 Paddles SHALL be fully independent; simultaneous moves on all paddles in one clock SHALL all apply.
REQ-029 at_min, at_max SHALL be combinational decodes of registered pos.

Reset
REQ-030 On reset assertion, immediately and independent of clk: all pos = POS_CENTER, at_min = at_max = 0, moving = 0, synchronisers = 1 (released), debounce/repeat counters = 0, steps = STEP_BASE.
REQ-031 Reset mid-hold SHALL discard the hold; after deassertion a still-held button SHALL requalify through full synchroniser + debounce latency before moving.

Verification
REQ-032 Defaults, hold btn_up_n[0]=0 from edge T0 -> pos[0] 220->210 at T0+6, 190 at T0+14, 150 at T0+22, clamp 140 at T0+30 (at_min[0]=1, moving pulses 4 times).
REQ-033 2-clock low glitch on btn_dn_n[1] -> no position change, moving[1] never asserts.
REQ-034 Both buttons of paddle 0 held, paddle 1 down held -> pos[0] stays 220; pos[1] 230, 250, 290, 330, 340.
REQ-035 Paddle 0 at 300, game_state 1->2 -> pos[0]=220 next clock; held buttons produce no movement until state returns to 1.
REQ-036 recenter pulse coincident with a scheduled move of paddle 1 at 250 -> pos[1]=220, no step applied.
REQ-037 Assert reset mid-hold at pos 190 -> pos=220 asynchronously; after release with button still held, first move to 210 at DEB_CYC+2 clocks.
